muntjac_ptw_pte_cache: RTL and testbench

- Responder-side block on the page-table walker memory port.
- Accepts 8-byte PTE read requests from the walker and answers hits from a small fully-associative PTE cache.
- Forwards misses to a downstream read port and fills the cache with the returned entry.
- Sits between muntjac_ptw and the data-side memory arbiter. `flush_i` is driven by SFENCE.VMA and satp writes.

---
 rtl/muntjac_pkg.sv | 26 ++
 rtl/muntjac_ptw_pte_cache_cam.sv | 66 ++++++
 rtl/muntjac_ptw_pte_cache.sv | 200 ++++++++++++++++++++
 tb/tb_muntjac_ptw_pte_cache.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muntjac_pkg.sv
// Shared definitions for the page-table walker PTE cache.
//
// Contents:
//   PhysAddrLen        physical address width (56)
//   PteTagLen          tag width, PhysAddrLen-3 (PTEs are 8-byte aligned)
//   PTE_V_BIT          index of the PTE valid bit
//   ptw_cache_state_e  request-handling state of the cache
//   pte_tag_to_addr    rebuilds a PTE byte address from a stored tag

package muntjac_pkg;

  localparam int PhysAddrLen = 56;
  localparam int PteTagLen   = PhysAddrLen - 3;
  localparam int PTE_V_BIT   = 0;

  typedef enum logic [1:0] {
    StateIdle = 2'd0,
    StateReq  = 2'd1,
    StateWait = 2'd2
  } ptw_cache_state_e;

  function automatic logic [PhysAddrLen-1:0] pte_tag_to_addr(input logic [PteTagLen-1:0] tag);
    return {tag, 3'b000};
  endfunction

endpackage

// File: rtl/muntjac_ptw_pte_cache_cam.sv
// Fully-associative storage for cached PTEs with a parallel tag compare.
//
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset (clears valid bits only)
//   lookup_tag     tag presented for the combinational compare
//   hit            some valid entry holds lookup_tag
//   hit_data       data of the matching entry (zero when no hit)
//   flush          clears every valid bit; wins over a simultaneous fill
//   fill_en        write fill_tag/fill_data into slot fill_idx and mark it valid
//   fill_idx       slot written by a fill
//   fill_tag       tag written by a fill
//   fill_data      PTE data written by a fill

module muntjac_ptw_pte_cache_cam
  import muntjac_pkg::*;
#(
  parameter int NumEntries = 8,
  localparam int IdxW = (NumEntries > 1) ? $clog2(NumEntries) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [PteTagLen-1:0] lookup_tag,
  output logic                 hit,
  output logic [63:0]          hit_data,
  input  logic                 flush,
  input  logic                 fill_en,
  input  logic [IdxW-1:0]      fill_idx,
  input  logic [PteTagLen-1:0] fill_tag,
  input  logic [63:0]          fill_data
);

  logic [NumEntries-1:0] valid_q;
  logic [PteTagLen-1:0]  tag_q  [NumEntries];
  logic [63:0]           data_q [NumEntries];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (fill_en) begin
      valid_q[fill_idx] <= 1'b1;
    end
  end

  // Tag and data need no reset: nothing reads them until the valid bit is set.
  always_ff @(posedge clk_i) begin
    if (fill_en) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= fill_data;
    end
  end

  // Tags are unique among valid entries, so OR-ing matching data is a clean mux.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int i = 0; i < NumEntries; i++) begin
      if (valid_q[i] && (tag_q[i] == lookup_tag)) begin
        hit      = 1'b1;
        hit_data = hit_data | data_q[i];
      end
    end
  end

endmodule

// File: rtl/muntjac_ptw_pte_cache.sv
// PTE cache between the page-table walker and the data-side memory arbiter.
// Answers 8-byte PTE reads from a small fully-associative cache; misses are
// forwarded downstream, and valid returned PTEs are cached round-robin.
// flush_i (SFENCE.VMA / satp write) invalidates the whole cache.
//
// Optional feature: define MUNTJAC_PTW_PTE_CACHE_STATS_EN to add saturating
// hit/miss counters on hit_count_o / miss_count_o.
//
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   flush_i             invalidate all cached entries
//   req_ready_o         walker request can be accepted (idle)
//   req_valid_i         walker request valid
//   req_address_i       PTE byte address, 8-byte aligned
//   resp_valid_o        one-cycle response strobe, no backpressure
//   resp_data_o         PTE data, meaningful only with resp_valid_o
//   mem_req_ready_i     downstream accepts the request
//   mem_req_valid_o     downstream request valid
//   mem_req_address_o   downstream address
//   mem_resp_valid_i    downstream response strobe
//   mem_resp_data_i     downstream response data
//   hit_count_o         (stats only) hit handshakes, saturating
//   miss_count_o        (stats only) miss handshakes, saturating

module muntjac_ptw_pte_cache
  import muntjac_pkg::*;
#(
  parameter int NumEntries = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  output logic                   req_ready_o,
  input  logic                   req_valid_i,
  input  logic [PhysAddrLen-1:0] req_address_i,
  output logic                   resp_valid_o,
  output logic [63:0]            resp_data_o,
  input  logic                   mem_req_ready_i,
  output logic                   mem_req_valid_o,
  output logic [PhysAddrLen-1:0] mem_req_address_o,
  input  logic                   mem_resp_valid_i,
  input  logic [63:0]            mem_resp_data_i
`ifdef MUNTJAC_PTW_PTE_CACHE_STATS_EN
  ,
  output logic [31:0]            hit_count_o,
  output logic [31:0]            miss_count_o
`endif
);

  localparam int IdxW = (NumEntries > 1) ? $clog2(NumEntries) : 1;

  ptw_cache_state_e     state_q, state_d;
  logic [PteTagLen-1:0] req_tag;
  logic [PteTagLen-1:0] miss_tag_q;
  logic                 resp_valid_q;
  logic [63:0]          resp_data_q;
  logic                 flush_pending_q;
  logic [IdxW-1:0]      repl_ptr_q;

  logic                 cam_hit;
  logic [63:0]          cam_hit_data;
  logic                 hit_accept;
  logic                 miss_accept;
  logic                 resp_event;
  logic                 mem_req_valid;
  logic                 fill_en;

  // The low address bits are always zero for an aligned PTE.
  logic                 unused_addr_bits;
  assign unused_addr_bits = ^req_address_i[2:0];

  assign req_tag = req_address_i[PhysAddrLen-1:3];

  // A response that carries an invalid PTE, or arrives after a flush that
  // raced the miss, must not populate the cache.
  assign fill_en = resp_event && mem_resp_data_i[PTE_V_BIT] && !flush_pending_q && !flush_i;

  muntjac_ptw_pte_cache_cam #(
    .NumEntries(NumEntries)
  ) u_cam (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .lookup_tag(req_tag),
    .hit       (cam_hit),
    .hit_data  (cam_hit_data),
    .flush     (flush_i),
    .fill_en   (fill_en),
    .fill_idx  (repl_ptr_q),
    .fill_tag  (miss_tag_q),
    .fill_data (mem_resp_data_i)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StateIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // A flush in the handshake cycle beats a hit, so that lookup becomes a miss.
  // A downstream response in the accept cycle completes the miss immediately.
  always_comb begin
    state_d       = state_q;
    hit_accept    = 1'b0;
    miss_accept   = 1'b0;
    resp_event    = 1'b0;
    mem_req_valid = 1'b0;
    unique case (state_q)
      StateIdle: begin
        if (req_valid_i) begin
          if (cam_hit && !flush_i) begin
            hit_accept = 1'b1;
          end else begin
            miss_accept = 1'b1;
            state_d     = StateReq;
          end
        end
      end
      StateReq: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready_i) begin
          if (mem_resp_valid_i) begin
            resp_event = 1'b1;
            state_d    = StateIdle;
          end else begin
            state_d = StateWait;
          end
        end
      end
      StateWait: begin
        if (mem_resp_valid_i) begin
          resp_event = 1'b1;
          state_d    = StateIdle;
        end
      end
      default: state_d = StateIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      resp_valid_q    <= 1'b0;
      resp_data_q     <= '0;
      miss_tag_q      <= '0;
      flush_pending_q <= 1'b0;
      repl_ptr_q      <= '0;
    end else begin
      resp_valid_q <= hit_accept | resp_event;
      if (hit_accept) begin
        resp_data_q <= cam_hit_data;
      end else if (resp_event) begin
        resp_data_q <= mem_resp_data_i;
      end
      if (miss_accept) begin
        miss_tag_q <= req_tag;
      end
      if (resp_event) begin
        flush_pending_q <= 1'b0;
      end else if (flush_i && (state_q != StateIdle)) begin
        flush_pending_q <= 1'b1;
      end
      if (fill_en) begin
        repl_ptr_q <= repl_ptr_q + IdxW'(1);
      end
    end
  end

  assign req_ready_o       = (state_q == StateIdle);
  assign resp_valid_o      = resp_valid_q;
  assign resp_data_o       = resp_data_q;
  assign mem_req_valid_o   = mem_req_valid;
  assign mem_req_address_o = pte_tag_to_addr(miss_tag_q);

`ifdef MUNTJAC_PTW_PTE_CACHE_STATS_EN
  logic [31:0] hit_count_q;
  logic [31:0] miss_count_q;

  // Counters saturate rather than wrap and ignore flushes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      if (hit_accept && (hit_count_q != 32'hFFFF_FFFF)) begin
        hit_count_q <= hit_count_q + 32'd1;
      end
      if (miss_accept && (miss_count_q != 32'hFFFF_FFFF)) begin
        miss_count_q <= miss_count_q + 32'd1;
      end
    end
  end

  assign hit_count_o  = hit_count_q;
  assign miss_count_o = miss_count_q;
`else
  // Statistics disabled: no counters are built.
`endif

endmodule

// File: tb/tb_muntjac_ptw_pte_cache.sv
// Self-checking bench for muntjac_ptw_pte_cache: a table of directed
// transactions, hand-written multi-cycle sequences, then random traffic
// checked against a FIFO-based model of the cache contents.
// Stats checks are included when MUNTJAC_PTW_PTE_CACHE_STATS_EN is defined.

module tb_muntjac_ptw_pte_cache;

  localparam int NumEntries = 8;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        flush_i = 1'b0;
  logic        req_ready_o;
  logic        req_valid_i = 1'b0;
  logic [55:0] req_address_i = '0;
  logic        resp_valid_o;
  logic [63:0] resp_data_o;
  logic        mem_req_ready_i = 1'b0;
  logic        mem_req_valid_o;
  logic [55:0] mem_req_address_o;
  logic        mem_resp_valid_i = 1'b0;
  logic [63:0] mem_resp_data_i = '0;
`ifdef MUNTJAC_PTW_PTE_CACHE_STATS_EN
  logic [31:0] hit_count_o;
  logic [31:0] miss_count_o;
`endif

  always #5 clk_i = ~clk_i;

  muntjac_ptw_pte_cache #(
    .NumEntries(NumEntries)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .flush_i          (flush_i),
    .req_ready_o      (req_ready_o),
    .req_valid_i      (req_valid_i),
    .req_address_i    (req_address_i),
    .resp_valid_o     (resp_valid_o),
    .resp_data_o      (resp_data_o),
    .mem_req_ready_i  (mem_req_ready_i),
    .mem_req_valid_o  (mem_req_valid_o),
    .mem_req_address_o(mem_req_address_o),
    .mem_resp_valid_i (mem_resp_valid_i),
    .mem_resp_data_i  (mem_resp_data_i)
`ifdef MUNTJAC_PTW_PTE_CACHE_STATS_EN
    ,
    .hit_count_o      (hit_count_o),
    .miss_count_o     (miss_count_o)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: cached PTEs in fill order, oldest first.
  typedef struct {
    logic [52:0] tag;
    logic [63:0] data;
  } ent_t;
  ent_t model_q[$];
  int   model_hits = 0;
  int   model_misses = 0;

  typedef struct {
    logic [55:0] addr;
    logic [63:0] mdata;
    int          rdy;
    int          rsp;
    int          flush_at;
    bit          flush_req;
    bit          exp_hit;
    logic [63:0] exp_data;
  } vec_t;
  vec_t vecs[$];

  typedef struct {
    bit          got;
    logic [63:0] data;
    int          nreq;
    logic [55:0] maddr;
    bit          lat_ok;
    bit          addr_stable;
  } obs_t;

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  function automatic int model_find(input logic [55:0] addr);
    for (int i = 0; i < model_q.size(); i++) begin
      if (model_q[i].tag == addr[55:3]) return i;
    end
    return -1;
  endfunction

  // Cache contents after one transaction, from the behavioural rules.
  task automatic model_update(input logic [55:0] addr, input logic [63:0] mdata,
                              input int flush_at, input bit flush_req, input bit hit);
    ent_t e;
    if (flush_req) model_q.delete();
    if (hit) begin
      model_hits++;
    end else begin
      model_misses++;
      if (flush_at > 0) begin
        model_q.delete();
      end else if (mdata[0]) begin
        e.tag  = addr[55:3];
        e.data = mdata;
        model_q.push_back(e);
        if (model_q.size() > NumEntries) void'(model_q.pop_front());
      end
    end
  endtask

  function automatic logic [63:0] pte_of(input logic [55:0] addr);
    return {addr[35:4], 16'hBEEF, 15'h0, addr[3]};
  endfunction

  // Issues one walker request and plays the downstream memory. Called and
  // returns at 1 time unit after a rising edge.
  task automatic apply_stimulus(input logic [55:0] addr, input logic [63:0] mdata,
                                input int rdy, input int rsp, input int flush_at,
                                input bit flush_req, output obs_t o);
    bit accepted = 0;
    bit sent = 0;
    int sent_c = -10;
    int rc = 0;
    int wc = 0;
    o.got = 0; o.data = '0; o.nreq = 0; o.maddr = '0; o.lat_ok = 0; o.addr_stable = 1;
    req_valid_i   = 1'b1;
    req_address_i = addr;
    flush_i       = flush_req;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    flush_i     = 1'b0;
    for (int c = 0; c < 64; c++) begin
      mem_req_ready_i  = 1'b0;
      mem_resp_valid_i = 1'b0;
      flush_i          = 1'b0;
      if (resp_valid_o) begin
        o.got    = 1;
        o.data   = resp_data_o;
        o.lat_ok = sent ? (c == sent_c + 1) : (c == 0);
        break;
      end
      if (mem_req_valid_o) begin
        if (accepted) begin
          o.nreq++;
        end else begin
          if (rc == 0) begin
            o.nreq++;
            o.maddr = mem_req_address_o;
          end else if (mem_req_address_o !== o.maddr) begin
            o.addr_stable = 0;
          end
          if (rc >= rdy) begin
            mem_req_ready_i = 1'b1;
            accepted = 1;
            if (rsp == 0) begin
              mem_resp_valid_i = 1'b1;
              mem_resp_data_i  = mdata;
              sent = 1;
              sent_c = c;
            end
          end
          rc++;
        end
      end else if (accepted && !sent) begin
        wc++;
        if (wc == flush_at) flush_i = 1'b1;
        if (wc >= rsp) begin
          mem_resp_valid_i = 1'b1;
          mem_resp_data_i  = mdata;
          sent = 1;
          sent_c = c;
        end
      end
      @(posedge clk_i); #1;
    end
    mem_req_ready_i  = 1'b0;
    mem_resp_valid_i = 1'b0;
    flush_i          = 1'b0;
  endtask

  task automatic check_output(input string name, input obs_t o, input bit exp_hit,
                              input logic [63:0] exp_data, input logic [55:0] addr);
    check_val({name, ".resp_seen"}, 64'(o.got), 64'd1);
    check_val({name, ".mem_reqs"}, 64'(o.nreq), exp_hit ? 64'd0 : 64'd1);
    check_val({name, ".data"}, o.data, exp_data);
    check_val({name, ".latency"}, 64'(o.lat_ok), 64'd1);
    if (!exp_hit) begin
      check_val({name, ".mem_addr"}, 64'(o.maddr), 64'({addr[55:3], 3'b000}));
      check_val({name, ".addr_stable"}, 64'(o.addr_stable), 64'd1);
    end
  endtask

  task automatic run_one(input string name, input logic [55:0] addr, input logic [63:0] mdata,
                         input int rdy, input int rsp, input int flush_at, input bit flush_req,
                         input bit exp_hit, input logic [63:0] exp_data);
    obs_t o;
    check_val({name, ".req_ready"}, 64'(req_ready_o), 64'd1);
    apply_stimulus(addr, mdata, rdy, rsp, flush_at, flush_req, o);
    check_output(name, o, exp_hit, exp_data, addr);
    model_update(addr, mdata, flush_at, flush_req, exp_hit);
  endtask

  function automatic vec_t mk(input logic [55:0] addr, input logic [63:0] mdata, input int rdy,
                              input int rsp, input int flush_at, input bit flush_req,
                              input bit exp_hit, input logic [63:0] exp_data);
    vec_t v;
    v.addr = addr; v.mdata = mdata; v.rdy = rdy; v.rsp = rsp; v.flush_at = flush_at;
    v.flush_req = flush_req; v.exp_hit = exp_hit; v.exp_data = exp_data;
    return v;
  endfunction

`ifdef MUNTJAC_PTW_PTE_CACHE_STATS_EN
  task automatic check_stats(input string name);
    check_val({name, ".hit_count"}, 64'(hit_count_o), 64'(model_hits));
    check_val({name, ".miss_count"}, 64'(miss_count_o), 64'(model_misses));
  endtask
`endif

  function automatic logic [63:0] rr_data(input int i);
    return 64'h0000_0000_4000_0001 + (64'(i) << 12);
  endfunction

  function automatic logic [55:0] rr_addr(input int i);
    return 56'h8000_4000 + 56'(8 * i);
  endfunction

  initial begin
    obs_t o;
    logic [55:0] a;
    bit fr, h;
    int fa, rsp, idx;

    // Reset state, sampled while reset is held.
    #2;
    check_val("reset.req_ready", 64'(req_ready_o), 64'd1);
    check_val("reset.resp_valid", 64'(resp_valid_o), 64'd0);
    check_val("reset.mem_req_valid", 64'(mem_req_valid_o), 64'd0);
`ifdef MUNTJAC_PTW_PTE_CACHE_STATS_EN
    check_stats("reset");
`endif
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Directed table.
    vecs.push_back(mk(56'h8000_1000, 64'h0000_0000_2000_0401, 2, 3, 0, 0, 0, 64'h0000_0000_2000_0401));
    vecs.push_back(mk(56'h8000_1000, 64'h0, 0, 0, 0, 0, 1, 64'h0000_0000_2000_0401));
    vecs.push_back(mk(56'h8000_2008, 64'h0, 1, 2, 0, 0, 0, 64'h0));
    vecs.push_back(mk(56'h8000_2008, 64'h0, 0, 1, 0, 0, 0, 64'h0));
    vecs.push_back(mk(56'h8000_3000, 64'h3001, 1, 3, 1, 0, 0, 64'h3001));
    vecs.push_back(mk(56'h8000_3000, 64'h3001, 0, 1, 0, 0, 0, 64'h3001));
    for (int i = 0; i < 9; i++)
      vecs.push_back(mk(rr_addr(i), rr_data(i), i % 3, i % 4, 0, 0, 0, rr_data(i)));
    vecs.push_back(mk(rr_addr(1), 64'h0, 0, 0, 0, 0, 1, rr_data(1)));
    vecs.push_back(mk(rr_addr(0), rr_data(0), 0, 2, 0, 0, 0, rr_data(0)));
    vecs.push_back(mk(rr_addr(2), 64'h0, 0, 0, 0, 0, 1, rr_data(2)));
    vecs.push_back(mk(rr_addr(1), rr_data(1), 1, 1, 0, 0, 0, rr_data(1)));
    vecs.push_back(mk(rr_addr(3), rr_data(3), 0, 1, 0, 1, 0, rr_data(3)));
    vecs.push_back(mk(rr_addr(3), 64'h0, 0, 0, 0, 0, 1, rr_data(3)));
    for (int i = 0; i < vecs.size(); i++)
      run_one($sformatf("vec%0d", i), vecs[i].addr, vecs[i].mdata, vecs[i].rdy, vecs[i].rsp,
              vecs[i].flush_at, vecs[i].flush_req, vecs[i].exp_hit, vecs[i].exp_data);

    // Back-to-back hits: one response per cycle, no downstream traffic.
    req_valid_i = 1'b1;
    req_address_i = rr_addr(3);
    @(posedge clk_i); #1;
    check_val("b2b.first_valid", 64'(resp_valid_o), 64'd1);
    check_val("b2b.first_data", resp_data_o, rr_data(3));
    check_val("b2b.first_ready", 64'(req_ready_o), 64'd1);
    check_val("b2b.first_memreq", 64'(mem_req_valid_o), 64'd0);
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    check_val("b2b.second_valid", 64'(resp_valid_o), 64'd1);
    check_val("b2b.second_data", resp_data_o, rr_data(3));
    check_val("b2b.second_memreq", 64'(mem_req_valid_o), 64'd0);
    model_hits += 2;
    @(posedge clk_i); #1;
    check_val("b2b.idle_valid", 64'(resp_valid_o), 64'd0);

    // Random traffic against the model.
    for (int n = 0; n < 70; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        flush_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        model_q.delete();
      end
      a   = 56'hA000_0000 + 56'(8 * $urandom_range(0, 11));
      rsp = $urandom_range(0, 3);
      fr  = ($urandom_range(0, 7) == 0);
      fa  = (rsp >= 1 && $urandom_range(0, 5) == 0) ? $urandom_range(1, rsp) : 0;
      idx = model_find(a);
      h   = !fr && (idx >= 0);
      run_one($sformatf("rand%0d", n), a, pte_of(a), $urandom_range(0, 3), rsp, fa, fr, h,
              h ? model_q[idx].data : pte_of(a));
    end

`ifdef MUNTJAC_PTW_PTE_CACHE_STATS_EN
    check_stats("pre_reset");
`endif

    // Asynchronous reset in the middle of a miss drops it and empties the cache.
    req_valid_i = 1'b1;
    req_address_i = 56'hB000_0000;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    check_val("rstmid.mem_req_valid_before", 64'(mem_req_valid_o), 64'd1);
    rst_ni = 1'b0;
    #1;
    check_val("rstmid.mem_req_valid", 64'(mem_req_valid_o), 64'd0);
    check_val("rstmid.req_ready", 64'(req_ready_o), 64'd1);
    check_val("rstmid.resp_valid", 64'(resp_valid_o), 64'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    model_q.delete();
    model_hits = 0;
    model_misses = 0;
    run_one("post_reset", rr_addr(3), rr_data(3), 0, 1, 0, 0, 0, rr_data(3));
    run_one("post_reset_hit", rr_addr(3), 64'h0, 0, 0, 0, 0, 1, rr_data(3));
`ifdef MUNTJAC_PTW_PTE_CACHE_STATS_EN
    check_stats("post_reset");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
